// File: rtl/control_nonce_pkg.sv
// Shared constants for the nonce initiator and its hash/compare partners.
package control_nonce_pkg;
  localparam int H_W         = 24;
  localparam int T_W         = 8;
  localparam int NONCE_W_DEF = 32;

  typedef logic [2:0] state_t;
  localparam state_t IDLE      = 3'd0;
  localparam state_t ISSUE     = 3'd1;
  localparam state_t WAIT_HASH = 3'd2;
  localparam state_t CHECK     = 3'd3;
  localparam state_t WAIT_RESP = 3'd4;
endpackage

// File: rtl/control_nonce_contador.sv
// Loadable nonce incrementer; tc flags the last nonce so the FSM can stop without wrapping.
module contador_nonce
  import control_nonce_pkg::*;
#(
  parameter int                 NONCE_W    = NONCE_W_DEF,
  parameter logic [NONCE_W-1:0] NONCE_INIT = '0,
  parameter logic [NONCE_W-1:0] NONCE_MAX  = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               inc,
  output logic [NONCE_W-1:0] q,
  output logic               tc
);
  logic [NONCE_W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_q <= NONCE_INIT;
    else if (load) r_q <= NONCE_INIT;
    else if (inc)  r_q <= r_q + 1'b1;
  end

  assign q  = r_q;
  assign tc = (r_q == NONCE_MAX);
endmodule

// File: rtl/control_nonce.sv
// Nonce search initiator: issue nonce, capture hash, hand it to the comparator, act on its reply.
module control_nonce
  import control_nonce_pkg::*;
#(
  parameter int                 NONCE_W    = NONCE_W_DEF,
  parameter logic [NONCE_W-1:0] NONCE_INIT = '0,
  parameter logic [NONCE_W-1:0] NONCE_MAX  = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [T_W-1:0]     target_in,
  input  logic               hash_done,
  input  logic [H_W-1:0]     hash_in,
  input  logic               valid,
  input  logic               next,
  output logic [NONCE_W-1:0] nonce,
  output logic               hash_start,
  output logic [H_W-1:0]     h,
  output logic               valid_hash,
  output logic [T_W-1:0]     target,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [NONCE_W-1:0] golden_nonce
);
  state_t             r_state, w_state_nxt;
  logic               w_abort, w_accept, w_cap, w_hit, w_rej, w_inc, w_exh, w_tc;
  logic [NONCE_W-1:0] w_nonce;
  logic               r_hash_start, r_valid_hash, r_busy, r_found, r_exhausted;
  logic [H_W-1:0]     r_h;
  logic [T_W-1:0]     r_target;
  logic [NONCE_W-1:0] r_golden;

  contador_nonce #(
    .NONCE_W(NONCE_W), .NONCE_INIT(NONCE_INIT), .NONCE_MAX(NONCE_MAX)
  ) u_cnt (
    .clk(clk), .reset(reset), .load(w_accept), .inc(w_inc), .q(w_nonce), .tc(w_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (stop && r_state != IDLE) w_state_nxt = IDLE;
    else begin
      case (r_state)
        IDLE:      if (start) w_state_nxt = ISSUE;
        ISSUE:     w_state_nxt = WAIT_HASH;
        WAIT_HASH: if (hash_done) w_state_nxt = CHECK;
        CHECK:     w_state_nxt = WAIT_RESP;
        WAIT_RESP: begin
          if (valid)     w_state_nxt = IDLE;
          else if (next) w_state_nxt = w_tc ? IDLE : ISSUE;
        end
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath strobes; stop masks every update so an abort leaves flags untouched.
  always_comb begin
    w_abort  = stop && (r_state != IDLE);
    w_accept = (r_state == IDLE) && start;
    w_cap    = (r_state == WAIT_HASH) && !w_abort && hash_done;
    w_hit    = (r_state == WAIT_RESP) && !w_abort && valid;
    w_rej    = (r_state == WAIT_RESP) && !w_abort && !valid && next;
    w_inc    = w_rej && !w_tc;
    w_exh    = w_rej && w_tc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hash_start <= 1'b0;
      r_valid_hash <= 1'b0;
      r_busy       <= 1'b0;
      r_found      <= 1'b0;
      r_exhausted  <= 1'b0;
      r_h          <= '0;
      r_target     <= '0;
      r_golden     <= '0;
    end else begin
      r_hash_start <= (w_state_nxt == ISSUE);
      r_valid_hash <= (w_state_nxt == CHECK);
      r_busy       <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_target    <= target_in;
        r_found     <= 1'b0;
        r_exhausted <= 1'b0;
      end
      if (w_cap) r_h <= hash_in;
      if (w_hit) begin
        r_found  <= 1'b1;
        r_golden <= w_nonce;
      end
      if (w_exh) r_exhausted <= 1'b1;
    end
  end

  assign nonce        = w_nonce;
  assign hash_start   = r_hash_start;
  assign h            = r_h;
  assign valid_hash   = r_valid_hash;
  assign target       = r_target;
  assign busy         = r_busy;
  assign found        = r_found;
  assign exhausted    = r_exhausted;
  assign golden_nonce = r_golden;
endmodule

// File: tb/tb_control_nonce.sv
// Directed bench for control_nonce: hash-core and comparator models plus a small 4-bit instance.
module tb_control_nonce;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Main instance (defaults: 32-bit nonce starting at 0)
  logic        start = 1'b0, stop = 1'b0;
  logic [7:0]  target_in = '0;
  logic        hm_done = 1'b0, man_done = 1'b0;
  logic [23:0] hm_hash = '0, man_hash = '0;
  logic        cm_valid = 1'b0, cm_next = 1'b0, man_valid = 1'b0, man_next = 1'b0;
  logic        hash_done, valid, nxt;
  logic [23:0] hash_in;
  logic [31:0] nonce, golden_nonce;
  logic [23:0] h;
  logic [7:0]  target;
  logic        hash_start, valid_hash, busy, found, exhausted;

  assign hash_done = hm_done | man_done;
  assign hash_in   = man_done ? man_hash : hm_hash;
  assign valid     = cm_valid | man_valid;
  assign nxt       = cm_next | man_next;

  control_nonce dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .target_in(target_in),
    .hash_done(hash_done), .hash_in(hash_in), .valid(valid), .next(nxt),
    .nonce(nonce), .hash_start(hash_start), .h(h), .valid_hash(valid_hash),
    .target(target), .busy(busy), .found(found), .exhausted(exhausted),
    .golden_nonce(golden_nonce)
  );

  // Small instance for the exhaustion corner
  logic        b_start = 1'b0, b_hash_done = 1'b0, b_next = 1'b0;
  logic [23:0] b_hash_in = '0;
  logic [3:0]  b_nonce, b_golden;
  logic [23:0] b_h;
  logic [7:0]  b_target;
  logic        b_hash_start, b_valid_hash, b_busy, b_found, b_exhausted;

  control_nonce #(.NONCE_W(4), .NONCE_INIT(4'd14)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(1'b0), .target_in(8'h40),
    .hash_done(b_hash_done), .hash_in(b_hash_in), .valid(1'b0), .next(b_next),
    .nonce(b_nonce), .hash_start(b_hash_start), .h(b_h), .valid_hash(b_valid_hash),
    .target(b_target), .busy(b_busy), .found(b_found), .exhausted(b_exhausted),
    .golden_nonce(b_golden)
  );

  // Hash core model: fixed latency after each hash_start
  logic [23:0] hm_val = '0;
  int          hm_cnt = 0;
  always @(posedge clk) begin
    hm_done <= 1'b0;
    if (hm_cnt != 0) begin
      hm_cnt <= hm_cnt - 1;
      if (hm_cnt == 1) begin
        hm_done <= 1'b1;
        hm_hash <= hm_val;
      end
    end else if (hash_start) hm_cnt <= 4;
  end

  // Comparator model: cm_nn rejects, then valid (optionally with next), or silence when held
  int cm_nn = 0, cm_idx = 0;
  bit cm_hold = 1'b0, cm_both = 1'b0;
  always @(posedge clk) begin
    cm_valid <= 1'b0;
    cm_next  <= 1'b0;
    if (start && !busy) cm_idx <= 0;
    else if (valid_hash) begin
      cm_idx <= cm_idx + 1;
      if (cm_idx < cm_nn) cm_next <= 1'b1;
      else if (!cm_hold) begin
        cm_valid <= 1'b1;
        cm_next  <= cm_both;
      end
    end
  end

  // Monitors
  int          hs_cnt = 0, vh_cnt = 0, vh_wide = 0;
  logic        vh_prev = 1'b0;
  logic [31:0] hs_nonce [64];
  always @(posedge clk) begin
    vh_prev <= valid_hash;
    if (hash_start) begin
      hs_nonce[hs_cnt % 64] <= nonce;
      hs_cnt <= hs_cnt + 1;
    end
    if (valid_hash) vh_cnt <= vh_cnt + 1;
    if (valid_hash && vh_prev) vh_wide <= vh_wide + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] t);
    target_in = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (busy && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(nm, {31'b0, busy}, 32'd0);
  endtask

  task automatic b_iter(output logic [3:0] seen);
    int c = 0;
    while (!b_hash_start && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("exh hash_start", {31'b0, b_hash_start}, 32'd1);
    seen = b_nonce;
    @(negedge clk);
    b_hash_done = 1'b1;
    b_hash_in   = 24'hFFFFFF;
    @(negedge clk);
    b_hash_done = 1'b0;
    chk("exh valid_hash", {31'b0, b_valid_hash}, 32'd1);
    @(negedge clk);
    b_next = 1'b1;
    @(negedge clk);
    b_next = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  tgt;
    logic [23:0] hv;
    int          nn;
    bit          both;
    logic [31:0] golden;
    int          iters;
  } vec_t;
  vec_t tv [4];

  initial begin
    int base_hs, base_vh, base_w, c;
    logic [3:0] n0, n1;
    tv[0] = '{8'h80, 24'h1020FF, 0, 1'b0, 32'd0, 1};
    tv[1] = '{8'h40, 24'h00AB12, 2, 1'b0, 32'd2, 3};
    tv[2] = '{8'h01, 24'hFFFFFF, 0, 1'b1, 32'd0, 1};
    tv[3] = '{8'hC3, 24'h123456, 4, 1'b1, 32'd4, 5};

    repeat (2) @(negedge clk);
    chk("por busy", {31'b0, busy}, 32'd0);
    chk("por found", {31'b0, found}, 32'd0);
    chk("por nonce", nonce, 32'd0);
    chk("por hash_start", {31'b0, hash_start}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      hm_val = tv[i].hv; cm_nn = tv[i].nn; cm_both = tv[i].both; cm_hold = 1'b0;
      base_hs = hs_cnt; base_vh = vh_cnt; base_w = vh_wide;
      do_start(tv[i].tgt);
      chk($sformatf("v%0d busy", i), {31'b0, busy}, 32'd1);
      chk($sformatf("v%0d found cleared", i), {31'b0, found}, 32'd0);
      wait_idle($sformatf("v%0d timeout", i));
      chk($sformatf("v%0d found", i), {31'b0, found}, 32'd1);
      chk($sformatf("v%0d exhausted", i), {31'b0, exhausted}, 32'd0);
      chk($sformatf("v%0d golden", i), golden_nonce, tv[i].golden);
      chk($sformatf("v%0d target", i), {24'b0, target}, {24'b0, tv[i].tgt});
      chk($sformatf("v%0d h", i), {8'b0, h}, {8'b0, tv[i].hv});
      chk($sformatf("v%0d hash_starts", i), hs_cnt - base_hs, tv[i].iters);
      chk($sformatf("v%0d valid_hashes", i), vh_cnt - base_vh, tv[i].iters);
      chk($sformatf("v%0d vh width", i), vh_wide - base_w, 32'd0);
      for (int k = 0; k < tv[i].iters; k++)
        chk($sformatf("v%0d nonce%0d", i, k), hs_nonce[(base_hs + k) % 64], k);
      @(negedge clk);
    end

    // Async reset during WAIT_HASH
    hm_val = 24'h5A5A5A; cm_nn = 0; cm_both = 1'b0;
    do_start(8'h5A);
    chk("golden kept on start", golden_nonce, 32'd4);
    @(negedge clk);
    chk("in wait_hash", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst busy", {31'b0, busy}, 32'd0);
    chk("arst golden", golden_nonce, 32'd0);
    chk("arst target", {24'b0, target}, 32'd0);
    chk("arst h", {8'b0, h}, 32'd0);
    chk("arst nonce", nonce, 32'd0);
    chk("arst found", {31'b0, found}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("late hash_done in idle", {8'b0, h}, 32'd0);

    // Abort in WAIT_RESP of nonce 5
    hm_val = 24'h0F0F0F; cm_nn = 5; cm_hold = 1'b1;
    base_vh = vh_cnt;
    do_start(8'h77);
    c = 0;
    while (vh_cnt - base_vh < 6 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("abort reach", vh_cnt - base_vh, 32'd6);
    chk("abort nonce", nonce, 32'd5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort found", {31'b0, found}, 32'd0);
    chk("abort exhausted", {31'b0, exhausted}, 32'd0);
    chk("abort valid_hash", {30'b0, valid_hash, hash_start}, 32'd0);
    repeat (2) @(negedge clk);
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    @(negedge clk);
    chk("late valid found", {31'b0, found}, 32'd0);
    chk("late valid golden", golden_nonce, 32'd0);
    cm_nn = 1; cm_hold = 1'b0;
    do_start(8'h11);
    chk("restart nonce", nonce, 32'd0);
    wait_idle("restart timeout");
    chk("restart found", {31'b0, found}, 32'd1);
    chk("restart golden", golden_nonce, 32'd1);

    // Stop in IDLE, start while busy
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle stop found", {31'b0, found}, 32'd1);
    cm_nn = 2; hm_val = 24'h00C0DE;
    base_hs = hs_cnt;
    do_start(8'h22);
    repeat (2) @(negedge clk);
    target_in = 8'hEE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy start target", {24'b0, target}, 32'h22);
    wait_idle("busy start timeout");
    chk("busy start golden", golden_nonce, 32'd2);
    chk("busy start iters", hs_cnt - base_hs, 32'd3);

    // hash_done during WAIT_RESP, then valid+next together
    cm_nn = 0; cm_hold = 1'b1; hm_val = 24'h314159;
    base_vh = vh_cnt;
    do_start(8'h33);
    c = 0;
    while (vh_cnt - base_vh < 1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("corner reach", vh_cnt - base_vh, 32'd1);
    man_hash = 24'hDEAD00;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("stray hash_done h", {8'b0, h}, 32'h314159);
    chk("stray hash_done vh", {31'b0, valid_hash}, 32'd0);
    chk("stray hash_done busy", {31'b0, busy}, 32'd1);
    man_valid = 1'b1; man_next = 1'b1;
    @(negedge clk);
    man_valid = 1'b0; man_next = 1'b0;
    chk("both found", {31'b0, found}, 32'd1);
    chk("both exhausted", {31'b0, exhausted}, 32'd0);
    chk("both nonce", nonce, 32'd0);
    chk("both busy", {31'b0, busy}, 32'd0);

    // Exhaustion on the 4-bit instance
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_iter(n0);
    b_iter(n1);
    chk("exh nonce0", {28'b0, n0}, 32'd14);
    chk("exh nonce1", {28'b0, n1}, 32'd15);
    chk("exh flag", {31'b0, b_exhausted}, 32'd1);
    chk("exh found", {31'b0, b_found}, 32'd0);
    chk("exh busy", {31'b0, b_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("exh no wrap", {28'b0, b_nonce}, 32'd15);
    chk("exh no restart", {31'b0, b_hash_start}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
